// File: rtl/mem_bus_ctrl.sv
// CPU-to-memory bus controller: one outstanding word/byte access with
// lane steering, misalignment rejection and a bounded wait for mem_ready.
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic        cpu_byte_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  mem_be_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;

    logic        misaligned;
    logic        timeout_hit;
    logic [7:0]  rd_lane;
    logic [31:0] rd_result;

    assign misaligned  = ~cpu_byte_i & (|cpu_addr_i[1:0]);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Little-endian lane pick: offset 0 is mem data bits [7:0]
    always_comb begin
        rd_lane = mem_rdata_i[7:0];
        case (off_q)
            2'd0: rd_lane = mem_rdata_i[7:0];
            2'd1: rd_lane = mem_rdata_i[15:8];
            2'd2: rd_lane = mem_rdata_i[23:16];
            2'd3: rd_lane = mem_rdata_i[31:24];
            default: rd_lane = mem_rdata_i[7:0];
        endcase
    end

    assign rd_result = we_q   ? '0 :
                       byte_q ? {24'h0, rd_lane} : mem_rdata_i;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            off_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    state_d = misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        byte_d  = byte_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
                if (cpu_req_i) begin
                    cnt_d  = '0;
                    we_d   = cpu_we_i;
                    byte_d = cpu_byte_i;
                    off_d  = cpu_addr_i[1:0];
                    if (misaligned) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        addr_d  = {cpu_addr_i[31:2], 2'b00};
                        be_d    = cpu_byte_i ? (4'b0001 << cpu_addr_i[1:0]) : 4'hF;
                        wdata_d = cpu_byte_i ? {4{cpu_wdata_i[7:0]}} : cpu_wdata_i;
                        rd_d    = ~cpu_we_i;
                        wr_d    = cpu_we_i;
                    end
                end
            end
            ACCESS: begin
                // mem_ready takes priority over an expiring wait counter
                if (mem_ready_i || timeout_hit) begin
                    ack_d   = 1'b1;
                    err_d   = ~mem_ready_i;
                    rdata_d = mem_ready_i ? rd_result : '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_ack_o   = ack_q;
    assign cpu_err_o   = err_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign mem_rd_o    = rd_q;
    assign mem_wr_o    = wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized self-checking bench for mem_bus_ctrl; each transaction's outcome
// is predicted from the access rules (alignment, lanes, ready delay vs TIMEOUT).
module tb_mem_bus_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_rd, mem_wr, mem_ready;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_byte_i  (cpu_byte),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_err_o   (cpu_err),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_be_o    (mem_be),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .mem_ready_i (mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_addr"},  mem_addr, 32'h0);
        chk({pfx, "_wdata"}, mem_wdata, 32'h0);
        chk({pfx, "_be"},    {28'h0, mem_be}, 32'h0);
        chk({pfx, "_strb"},  {30'h0, mem_rd, mem_wr}, 32'h0);
        chk({pfx, "_ackerr"}, {30'h0, cpu_ack, cpu_err}, 32'h0);
        chk({pfx, "_rdata"}, cpu_rdata, 32'h0);
    endtask

    // Call right after an edge with the DUT idle at the next edge.
    // delay = number of ACCESS cycles with mem_ready low before it is raised.
    task automatic run_txn(input logic we, input logic byt, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword,
                           input int unsigned delay, input logic hold_req);
        logic        mis, exp_err, first, stable, both, got_ack, err_alone, f_rd;
        logic [31:0] exp_addr, exp_wdata, exp_rdata, f_addr, f_wdata, ack_rdata;
        logic [3:0]  exp_be, f_be;
        logic        ack_err;
        int unsigned exp_n, strobes, ack_cyc;
        int unsigned off;

        off      = int'(addr[1:0]);
        mis      = !byt && (off != 0);
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_be   = byt ? 4'(1 << off) : 4'hF;
        exp_wdata = byt ? (wdata[7:0] * 32'h0101_0101) : wdata;
        if (mis) begin
            exp_n   = 0;
            exp_err = 1'b1;
        end else if (delay < TO) begin
            exp_n   = delay + 1;
            exp_err = 1'b0;
        end else begin
            exp_n   = TO;
            exp_err = 1'b1;
        end
        if (exp_err || we) exp_rdata = 32'h0;
        else if (byt)      exp_rdata = (rword / (32'h1 << (8 * off))) % 256;
        else               exp_rdata = rword;

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_byte  = byt;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;

        first = 1'b1; stable = 1'b1; both = 1'b0; got_ack = 1'b0; err_alone = 1'b0;
        strobes = 0; ack_cyc = 0; ack_err = 1'b0; ack_rdata = '0;
        f_addr = '0; f_wdata = '0; f_be = '0; f_rd = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_ack; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                cpu_we    = 1'($urandom);
                cpu_byte  = 1'($urandom);
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
            if (mem_rd || mem_wr) begin
                if (mem_rd && mem_wr) both = 1'b1;
                if (first) begin
                    f_addr = mem_addr; f_wdata = mem_wdata; f_be = mem_be; f_rd = mem_rd;
                    first = 1'b0;
                end else if (mem_addr !== f_addr || mem_wdata !== f_wdata ||
                             mem_be !== f_be || mem_rd !== f_rd) begin
                    stable = 1'b0;
                end
                mem_ready = (strobes == delay);
                mem_rdata = mem_ready ? rword : $urandom;
                strobes++;
            end else begin
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
            if (cpu_err && !cpu_ack) err_alone = 1'b1;
            if (cpu_ack) begin
                got_ack   = 1'b1;
                ack_cyc   = cyc;
                ack_err   = cpu_err;
                ack_rdata = cpu_rdata;
            end
        end

        chk("ack_seen", {31'h0, got_ack}, 32'h1);
        chk("latency", ack_cyc, exp_n);
        chk("strobe_cycles", strobes, exp_n);
        if (exp_n > 0) begin
            chk("mem_addr", f_addr, exp_addr);
            chk("mem_be", {28'h0, f_be}, {28'h0, exp_be});
            chk("mem_wdata", f_wdata, exp_wdata);
            chk("dir_rd", {31'h0, f_rd}, {31'h0, !we});
            chk("stable", {31'h0, stable}, 32'h1);
            chk("both_strobes", {31'h0, both}, 32'h0);
        end
        chk("err_no_ack", {31'h0, err_alone}, 32'h0);
        chk("cpu_err", {31'h0, ack_err}, {31'h0, exp_err});
        chk("cpu_rdata", ack_rdata, exp_rdata);

        if (!hold_req) cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_clear", {30'h0, cpu_ack, cpu_err}, 32'h0);
        chk("rdata_clear", cpu_rdata, 32'h0);
        chk("idle_quiet", {30'h0, mem_rd, mem_wr}, 32'h0);
    endtask

    initial begin
        logic        r_we, r_byt, r_hold;
        logic [31:0] r_addr, r_wdata, r_word;
        int unsigned r_delay;

        n_reset   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_byte  = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        n_reset = 1'b1;

        run_txn(1'b0, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h1122_3344, 0, 1'b0);
        run_txn(1'b1, 1'b1, 32'h0000_0203, 32'h0000_00A5, 32'h0, 3, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h1122_3344, 0, 1'b0);
        run_txn(1'b0, 1'b0, 32'h0000_0006, 32'h0, 32'h1122_3344, 0, 1'b0);
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 10, 1'b1);
        run_txn(1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'h0BAD_CAFE, TO - 1, 1'b0);

        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_byte  = 1'b0;
        cpu_addr  = 32'h0000_0040;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_rd", {31'h0, mem_rd}, 32'h1);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        cpu_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_no_ack", {31'h0, cpu_ack}, 32'h0);
        end
        @(negedge clk);
        n_reset = 1'b1;
        run_txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h5566_7788, 1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            r_we    = 1'($urandom);
            r_byt   = 1'($urandom);
            r_addr  = $urandom;
            if (!r_byt && ($urandom % 4 != 0)) r_addr[1:0] = 2'b00;
            r_wdata = $urandom;
            r_word  = $urandom;
            r_delay = $urandom_range(0, 6);
            r_hold  = 1'($urandom);
            run_txn(r_we, r_byt, r_addr, r_wdata, r_word, r_delay, r_hold);
        end
        cpu_req = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
